// File: rtl/monpro_rk_if.sv
`default_nettype none
// ============================================================================
// monpro_rk_if : request / result handshake bundle for the monpro_rk unit
// Rev 1.0
// ============================================================================
interface monpro_rk_if #(
  parameter int DATAWIDTH = 256,
  parameter int K         = 4
);
  logic                 start;
  logic                 ready;
  logic [DATAWIDTH-1:0] i_A;
  logic [DATAWIDTH-1:0] i_B;
  logic [DATAWIDTH-1:0] i_N;
  logic [K-1:0]         i_Nprime;
  logic                 o_valid;
  logic                 i_out_ready;
  logic [DATAWIDTH-1:0] o_U;

  modport master (
    output start, i_A, i_B, i_N, i_Nprime, i_out_ready,
    input  ready, o_valid, o_U
  );

  modport slave (
    input  start, i_A, i_B, i_N, i_Nprime, i_out_ready,
    output ready, o_valid, o_U
  );
endinterface
`default_nettype wire

// File: rtl/monpro_rk.sv
`default_nettype none
// ============================================================================
// monpro_rk : radix-2^K Montgomery product U = A*B*2^-DATAWIDTH mod N
// Rev 1.0
// ============================================================================
module monpro_rk #(
  parameter int DATAWIDTH = 256,
  parameter int K         = 4
) (
  input  logic       clk,
  input  logic       rstn,
  monpro_rk_if.slave bus
);

  localparam int L    = DATAWIDTH / K;
  localparam int ACCW = DATAWIDTH + K + 2;
  localparam int CW   = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  generate
    if ((DATAWIDTH % K) != 0) begin : g_bad_width
      $error("monpro_rk: DATAWIDTH must be a multiple of K");
    end
    if (!(K == 1 || K == 2 || K == 4 || K == 8)) begin : g_bad_k
      $error("monpro_rk: K must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOP = 2'd1,
    ST_SUB  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic [DATAWIDTH-1:0] n_q, n_d;
  logic [K-1:0]         np_q, np_d;
  logic [ACCW-1:0]      u_q, u_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] res_q, res_d;

  logic [K-1:0]         digit;
  logic [K-1:0]         m_dig;
  logic [ACCW-1:0]      n_ext;
  logic [ACCW-1:0]      t_sum;
  logic [ACCW-1:0]      tm_sum;
  logic [ACCW-1:0]      u_shift;
  logic [ACCW-1:0]      u_red;
  logic                 unused_bits;

  // A is consumed low digit first by shifting it down each iteration.
  assign digit   = a_q[K-1:0];
  assign n_ext   = {{(ACCW-DATAWIDTH){1'b0}}, n_q};
  assign t_sum   = u_q + ({{(ACCW-K){1'b0}}, digit} * {{(ACCW-DATAWIDTH){1'b0}}, b_q});
  assign m_dig   = t_sum[K-1:0] * np_q;
  assign tm_sum  = t_sum + ({{(ACCW-K){1'b0}}, m_dig} * n_ext);
  assign u_shift = {{K{1'b0}}, tm_sum[ACCW-1:K]};
  assign u_red   = (u_q >= n_ext) ? (u_q - n_ext) : u_q;

  // Low digit of t+m*N is zero by construction; the reduced top bits are zero since U < N.
  assign unused_bits = ^{tm_sum[K-1:0], u_red[ACCW-1:DATAWIDTH]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    np_d    = np_q;
    u_d     = u_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.i_A;
          b_d     = bus.i_B;
          n_d     = bus.i_N;
          np_d    = bus.i_Nprime;
          u_d     = '0;
          cnt_d   = '0;
          state_d = ST_LOOP;
        end
      end
      ST_LOOP: begin
        u_d   = u_shift;
        a_d   = a_q >> K;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        res_d   = u_red[DATAWIDTH-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.i_out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      np_q    <= '0;
      u_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      np_q    <= np_d;
      u_q     <= u_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // ready is masked by rstn so it reads low for the whole reset window.
  assign bus.ready   = rstn && (state_q == ST_IDLE);
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.o_U     = res_q;

endmodule
`default_nettype wire

// File: tb/tb_monpro_rk.sv
`default_nettype none
// ============================================================================
// tb_monpro_rk : directed bench for monpro_rk (K=1, K=4 at 256 bits; K=2 at 8 bits)
// Rev 1.0
// ============================================================================
module tb_monpro_rk;

  localparam logic [255:0] VA = 256'h1f94373be50b1cc0ced44eebde66dd7acb02d59c51941d2497184c45aab39f5f;
  localparam logic [255:0] VN = 256'h2e5f7417fd9c9471c4ee1077900d7e4051e4d3f682b95bc27f5d128e05df33b5;
  localparam logic [255:0] VU = 256'h01362a24b630a8e265b65d361fb91a90e5a2dc8b25bb2ccc2afc1d440adedd68;

  logic clk = 1'b0;
  logic rstn1 = 1'b0;
  logic rstn4 = 1'b0;
  logic rstn8 = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  monpro_rk_if #(.DATAWIDTH(256), .K(1)) if1 ();
  monpro_rk_if #(.DATAWIDTH(256), .K(4)) if4 ();
  monpro_rk_if #(.DATAWIDTH(8),   .K(2)) if8 ();

  monpro_rk #(.DATAWIDTH(256), .K(1)) u_dut1 (.clk(clk), .rstn(rstn1), .bus(if1));
  monpro_rk #(.DATAWIDTH(256), .K(4)) u_dut4 (.clk(clk), .rstn(rstn4), .bus(if4));
  monpro_rk #(.DATAWIDTH(8),   .K(2)) u_dut8 (.clk(clk), .rstn(rstn8), .bus(if8));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic [1:0] np;
    logic [7:0] u;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic dut_valid(input int s);
    case (s)
      0:       return if1.o_valid;
      1:       return if4.o_valid;
      default: return if8.o_valid;
    endcase
  endfunction

  function automatic logic dut_ready(input int s);
    case (s)
      0:       return if1.ready;
      1:       return if4.ready;
      default: return if8.ready;
    endcase
  endfunction

  function automatic logic [255:0] dut_u(input int s);
    case (s)
      0:       return if1.o_U;
      1:       return if4.o_U;
      default: return {248'd0, if8.o_U};
    endcase
  endfunction

  task automatic drive(input int s, input logic st, input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] n, input logic [7:0] np);
    case (s)
      0: begin
        if1.start = st; if1.i_A = a; if1.i_B = b; if1.i_N = n; if1.i_Nprime = np[0:0];
      end
      1: begin
        if4.start = st; if4.i_A = a; if4.i_B = b; if4.i_N = n; if4.i_Nprime = np[3:0];
      end
      default: begin
        if8.start = st; if8.i_A = a[7:0]; if8.i_B = b[7:0]; if8.i_N = n[7:0]; if8.i_Nprime = np[1:0];
      end
    endcase
  endtask

  task automatic set_or(input int s, input logic v);
    case (s)
      0:       if1.i_out_ready = v;
      1:       if4.i_out_ready = v;
      default: if8.i_out_ready = v;
    endcase
  endtask

  // Accept, wait for o_valid (bounded), check latency and result.
  // Leaves the caller #1 after the edge on which o_valid is first seen high.
  task automatic start_and_wait(input int s, input logic [255:0] a, input logic [255:0] b,
                                input logic [255:0] n, input logic [7:0] np,
                                input logic [255:0] exp, input int lat, input string nm);
    int cyc;
    chk({nm, " ready"}, 256'(dut_ready(s)), 256'd1);
    drive(s, 1'b1, a, b, n, np);
    @(posedge clk); #1;
    drive(s, 1'b0, ~a, ~b, ~n, ~np);
    cyc = 0;
    while (!dut_valid(s) && cyc < lat + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, 256'(cyc), 256'(lat));
    chk({nm, " U"}, dut_u(s), exp);
  endtask

  task automatic run(input int s, input logic [255:0] a, input logic [255:0] b,
                     input logic [255:0] n, input logic [7:0] np,
                     input logic [255:0] exp, input int lat, input string nm);
    start_and_wait(s, a, b, n, np, exp, lat, nm);
    set_or(s, 1'b1);
    @(posedge clk); #1;
    set_or(s, 1'b0);
    chk({nm, " valid_drop"}, 256'(dut_valid(s)), 256'd0);
    chk({nm, " ready_back"}, 256'(dut_ready(s)), 256'd1);
  endtask

  initial begin : main
    bit seen;
    vecs[0]  = '{8'd6,   8'd6,   8'd7,   2'd1, 8'd2};
    vecs[1]  = '{8'd0,   8'd5,   8'd7,   2'd1, 8'd0};
    vecs[2]  = '{8'd1,   8'd1,   8'd7,   2'd1, 8'd2};
    vecs[3]  = '{8'd3,   8'd4,   8'd7,   2'd1, 8'd3};
    vecs[4]  = '{8'd5,   8'd6,   8'd7,   2'd1, 8'd4};
    vecs[5]  = '{8'd2,   8'd3,   8'd7,   2'd1, 8'd5};
    vecs[6]  = '{8'd4,   8'd4,   8'd5,   2'd3, 8'd1};
    vecs[7]  = '{8'd3,   8'd2,   8'd5,   2'd3, 8'd1};
    vecs[8]  = '{8'd12,  8'd12,  8'd13,  2'd3, 8'd3};
    vecs[9]  = '{8'd5,   8'd7,   8'd13,  2'd3, 8'd1};
    vecs[10] = '{8'd254, 8'd254, 8'd255, 2'd1, 8'd1};
    vecs[11] = '{8'd200, 8'd2,   8'd255, 2'd1, 8'd145};
    vecs[12] = '{8'd128, 8'd128, 8'd255, 2'd1, 8'd64};

    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, '0, '0, '0, '0);
      set_or(s, 1'b0);
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("reset ready", 256'(dut_ready(s)), 256'd0);
      chk("reset valid", 256'(dut_valid(s)), 256'd0);
      chk("reset U", dut_u(s), 256'd0);
    end
    rstn1 = 1'b1; rstn4 = 1'b1; rstn8 = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) chk("post-reset ready", 256'(dut_ready(s)), 256'd1);

    // Table-driven small vectors
    for (int i = 0; i < 13; i++) begin
      run(2, 256'(vecs[i].a), 256'(vecs[i].b), 256'(vecs[i].n), 8'(vecs[i].np),
          256'(vecs[i].u), 5, $sformatf("vec%0d", i));
    end

    run(0, VA, VA, VN, 8'd1, VU, 257, "k1");
    run(1, VA, VA, VN, 8'd3, VU, 65, "k4");

    // Backpressure with an ignored start pulse
    start_and_wait(2, 256'd6, 256'd6, 256'd7, 8'd1, 256'd2, 5, "bp");
    for (int i = 0; i < 10; i++) begin
      chk("bp hold valid", 256'(if8.o_valid), 256'd1);
      chk("bp hold U", 256'(if8.o_U), 256'd2);
      chk("bp hold ready", 256'(if8.ready), 256'd0);
      drive(2, (i == 3), 256'd3, 256'd4, 256'd7, 8'd1);
      @(posedge clk); #1;
    end
    drive(2, 1'b0, '0, '0, '0, '0);
    set_or(2, 1'b1);
    @(posedge clk); #1;
    set_or(2, 1'b0);
    chk("bp release valid", 256'(if8.o_valid), 256'd0);
    chk("bp release ready", 256'(if8.ready), 256'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if8.o_valid || !if8.ready) seen = 1'b1;
    end
    chk("bp start ignored", 256'(seen), 256'd0);

    // Reset in the middle of a K=1 run
    drive(0, 1'b1, VA, VA, VN, 8'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, '0);
    repeat (20) begin
      @(posedge clk); #1;
    end
    rstn1 = 1'b0;
    @(posedge clk); #1;
    chk("midrst valid", 256'(if1.o_valid), 256'd0);
    chk("midrst U", if1.o_U, 256'd0);
    chk("midrst ready low", 256'(if1.ready), 256'd0);
    rstn1 = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready", 256'(if1.ready), 256'd1);
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (if1.o_valid || !if1.ready) seen = 1'b1;
    end
    chk("midrst no spurious", 256'(seen), 256'd0);
    run(0, VA, VA, VN, 8'd1, VU, 257, "k1 restart");

    // Back-to-back with the consumer always ready
    set_or(2, 1'b1);
    start_and_wait(2, 256'd6, 256'd6, 256'd7, 8'd1, 256'd2, 5, "b2b first");
    @(posedge clk); #1;
    chk("b2b valid one cycle", 256'(if8.o_valid), 256'd0);
    start_and_wait(2, 256'd3, 256'd4, 256'd7, 8'd1, 256'd3, 5, "b2b second");
    @(posedge clk); #1;
    chk("b2b second drop", 256'(if8.o_valid), 256'd0);
    set_or(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/monpro_rk.md
# monpro_rk

Parametrised radix-2^K Montgomery product unit, successor to the bit-serial `monpro`. It computes U = A·B·R⁻¹ mod N with R = 2^DATAWIDTH, retiring K multiplier bits per cycle. The block sits under the modular-exponentiation core. It adds a selectable digit width, a result-hold/backpressure handshake and a final conditional subtraction, so the output is always fully reduced.

## Interface
- `DATAWIDTH`, default 256: operand and result width. Must satisfy DATAWIDTH % K == 0, otherwise elaboration fails.
- `K`, default 4: digit width in bits (1, 2, 4 or 8). Iteration count is L = DATAWIDTH/K.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: clock; all state updates on rising edge.
- `rstn` input 1: synchronous active-low reset.
- `start` input 1: request a product; accepted only when `ready`=1.
- `ready` output 1: block idle and able to accept `start`.
- `i_A` input DATAWIDTH: multiplicand, A < N; latched on accept.
- `i_B` input DATAWIDTH: multiplier, B < N; latched on accept.
- `i_N` input DATAWIDTH: odd modulus; latched on accept.
- `i_Nprime` input K: −N⁻¹ mod 2^K; latched on accept.
- `o_valid` output 1: o_U holds a valid result.
- `i_out_ready` input 1: consumer accepts the result.
- `o_U` output DATAWIDTH: result, fully reduced (< N).

## Operation
- States: IDLE, LOOP, SUB, DONE.
- **IDLE**
  - `ready`=1.
  - On `start`=1: latch A, B, N, N′; clear accumulator U; clear digit counter i; go to LOOP.
- **LOOP**, one iteration per cycle, i = 0..L−1:
  - a = A[K·i +: K]
  - t = U + a·B
  - m = (t[K−1:0]·N′) mod 2^K
  - U ← (t + m·N) >> K
  - The low K bits of t + m·N are zero by construction.
  - At i = L−1, go to SUB.
- **SUB**: if U ≥ N then U ← U − N; register into `o_U`; go to DONE.
- **DONE**
  - `o_valid`=1 and `o_U` held stable.
  - When `i_out_ready`=1, the handshake completes at that edge; go to IDLE.
- Width rules:
  - The accumulator is DATAWIDTH+K+2 bits wide. Intermediate sums must not truncate.
  - The invariant U < 2N holds after every iteration, so one subtraction suffices.
- `ready`=1 only in IDLE. `start` in LOOP, SUB or DONE is ignored, with no queueing.
- Operand inputs are don't-care except in the accept cycle.
- Behaviour for even N, or for A or B ≥ N, is undefined.

## Timing
- Reset values: `ready`=0 during reset and 1 from the first cycle after reset is released; `o_valid`=0; `o_U`=0; state IDLE.
- Latency:
  - Start accepted at edge E0; LOOP iterations occur at edges E1..E_L; SUB at E_{L+1}.
  - `o_valid` is high from E_{L+1}, i.e. L+1 cycles after accept.
  - Examples: 257 cycles for DATAWIDTH=256, K=1; 65 cycles for K=4.
- `o_valid` stays high until the cycle in which `i_out_ready`=1. It deasserts, and `ready` asserts, at the following edge.
- If `i_out_ready` is already high when `o_valid` rises, the result is valid for exactly one cycle.
- The earliest next accept is one cycle after the output handshake, giving a throughput of one product per L+3 cycles minimum.
- `o_U` keeps its last value after the handshake until the next SUB.
- Reset mid-operation (LOOP, SUB or DONE): at the reset edge go to IDLE, `o_valid`=0, `o_U`=0, discard the in-flight result.
- `start` and `rstn`=0 in the same cycle: reset wins; the start is not accepted.

## Test plan
- **K=1, DATAWIDTH=256 vector.**
  - Stimulus: A = B = 0x1f94373be50b1cc0ced44eebde66dd7acb02d59c51941d2497184c45aab39f5f, N = 0x2e5f7417fd9c9471c4ee1077900d7e4051e4d3f682b95bc27f5d128e05df33b5, N′ = 1.
  - Required: U = 0x01362a24b630a8e265b65d361fb91a90e5a2dc8b25bb2ccc2afc1d440adedd68, with `o_valid` rising 257 cycles after accept.
- **K=4, same vector**, N′ = 4'h3 → identical U, with `o_valid` 65 cycles after accept.
- **DATAWIDTH=8, K=2, N=7, N′=1.**
  - A=6, B=6 → U=2.
  - A=0, B=5 → U=0.
  - Each result appears 5 cycles after accept.
- **Backpressure.**
  - Hold `i_out_ready`=0 for 10 cycles after `o_valid` rises and pulse `start` during that time.
  - Required: `o_valid` stays 1, `o_U` stays stable, `ready`=0 and the start is ignored.
  - Then raise `i_out_ready` for one cycle → `o_valid`=0 and `ready`=1 at the next edge.
- **Reset mid-operation.**
  - Assert `rstn`=0 for one cycle, 20 cycles into the K=1 run.
  - Required: state IDLE, `o_valid`=0, `o_U`=0 and no spurious `o_valid`.
  - Then restart with the K=1 vector → correct U after 257 cycles.
- **Back-to-back.** Run two products with `i_out_ready` tied high. The second start is accepted at the first cycle `ready`=1 and both results match expected values.
